pll_lock_rst_seq: RTL and testbench
===================================

Name: pll_lock_rst_seq

Overview:
- Reset and lock sequencer that sits around the PLLVR clock generator.
- Drives the PLL RESET input, watches its asynchronous LOCK output, and releases the downstream system reset for the QSPI/bus logic only after lock has been stable.
- Retries the PLL on lock timeout, flags permanent failure, and re-sequences on lock loss.
- Clocked from the PLL reference clock (free-running), not from the PLL output.

Parameters:
- SYNC_STAGES, 2, flops in the lock synchronizer (min 2).
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (min 1).
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry.
- STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before release.
- MAX_RETRY, 3, retries allowed after the first attempt before FAIL.
- LOSS_FILTER, 4, consecutive synchronized-lock-low cycles in RUN that count as lock loss.

Ports:
- clk, input, 1, PLL reference clock.
- rst, input, 1, async active-high reset.
- lock, input, 1, PLL LOCK; asynchronous to clk.
- pll_rst, output, 1, to PLL RESET; active-high.
- sys_rst, output, 1, downstream reset; active-high.
- ready, output, 1, high while in RUN.
- fail, output, 1, sticky; PLL never locked.
- retry_cnt, output, $clog2(MAX_RETRY+1), retries used in the current sequence.
- loss_cnt, output, 8, lock-loss events; saturates at 255.
- state, output, 3, current FSM state, for debug.

Behaviour:
- Reset: rst is an asynchronous, active-high reset. While asserted: state=PLLRST, pll_rst=1, sys_rst=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0, timer=0, synchronizer flops=0.
- Lock synchronization: lock passes through SYNC_STAGES flops to give lock_s. Lock-to-lock_s latency is SYNC_STAGES cycles. The FSM uses only lock_s.
- All outputs are registered.
- State encodings: PLLRST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLLRST:
  - pll_rst=1, sys_rst=1.
  - Timer counts 0..PLL_RST_CYCLES-1, then go to WAIT_LOCK with timer=0.
  - pll_rst is low from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - If lock_s=1, go to STABLE with timer=0.
  - Otherwise, when timer==LOCK_TIMEOUT-1:
    - if retry_cnt==MAX_RETRY, go to FAIL;
    - else retry_cnt+1 and go to PLLRST.
  - If lock_s=1 on the timeout cycle, lock wins and the FSM goes to STABLE.
- STABLE:
  - If lock_s=0 on any cycle, go to WAIT_LOCK with timer=0; retry_cnt is unchanged.
  - When timer==STABLE_CYCLES-1 with lock_s=1, go to RUN.
  - sys_rst=0 and ready=1 in the first RUN cycle.
- RUN:
  - A loss counter counts consecutive lock_s=0 cycles and clears on lock_s=1.
  - When it reaches LOSS_FILTER: sys_rst=1 and ready=0 on the next cycle, loss_cnt+1 (saturating), retry_cnt=0, go to PLLRST.
  - Low runs shorter than LOSS_FILTER are ignored.
- FAIL:
  - Terminal until rst.
  - pll_rst=0, sys_rst=1, fail=1, ready=0.
  - lock activity is ignored.
- sys_rst asserts within one cycle of any state change out of RUN. It is never released outside RUN.
- Timer width: $clog2 of the maximum of PLL_RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES. The timer clears on every state transition.
- rst mid-operation: asynchronous return to reset values. loss_cnt is cleared.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state_t enum with the encodings above;
  - the LOSS_CNT_W=8 constant.
- One sub-module, sync_ff: parameterised-depth synchronizer with async active-high reset to 0. Instantiated once, for lock.
- FSM, timer and counters stay in pll_lock_rst_seq.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRY=2, LOSS_FILTER=3.
1. Clean bring-up: release rst; raise lock 10 cycles after pll_rst falls -> pll_rst high for 4 cycles; sys_rst falls and ready rises 2+8 cycles after lock rises (±1 for the registered output); retry_cnt=0.
2. Timeout retry then lock: hold lock low through two timeouts, then raise it -> two further pll_rst pulses of 4 cycles, retry_cnt=2, then RUN reached; fail=0.
3. Permanent failure: lock tied low -> three 4-cycle pll_rst pulses, then fail=1, state=4, sys_rst=1; a later lock rise is ignored until rst.
4. Stability glitch: in STABLE, drop lock for 1 cycle at stable timer=5 -> returns to WAIT_LOCK; full 8 stable cycles are required again; retry_cnt unchanged.
5. RUN glitch filter: drop lock for 2 cycles -> ready stays 1, loss_cnt=0. Then drop lock for 3 cycles -> sys_rst=1, loss_cnt=1, state=PLLRST, retry_cnt=0; re-raising lock reaches RUN again.
6. Async reset mid-STABLE: assert rst without a clock edge -> pll_rst=1, sys_rst=1, ready=0 immediately; all counters 0 after release.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
// The state encodings are visible on the debug port, so their values are fixed.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/pll_lock_rst_seq_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level input.
// The flops clear to 0 on reset so the input reads as deasserted until re-sampled.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: async reset in the sensitivity list, and <= for every flop so the chain shifts by exactly one stage per edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_seq.sv
// Sequences PLL reset, waits for a stable lock, then releases the system reset.
// Retries on lock timeout, fails permanently after MAX_RETRY retries, re-sequences on lock loss.
module pll_lock_rst_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int LOSS_FILTER    = 4,
    localparam int TMR_MAX_A     = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT,
    localparam int TMR_MAX       = (TMR_MAX_A > STABLE_CYCLES) ? TMR_MAX_A : STABLE_CYCLES,
    localparam int TMR_W         = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1,
    localparam int RC_W          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
    localparam int LF_W          = $clog2(LOSS_FILTER + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lock,
    output logic                  pll_rst,
    output logic                  sys_rst,
    output logic                  ready,
    output logic                  fail,
    output logic [RC_W-1:0]       retry_cnt,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output logic [2:0]            state
);

    logic lock_s;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (lock),
        .q_o (lock_s)
    );

    state_t                state_q,  state_d;
    logic [TMR_W-1:0]      timer_q,  timer_d;
    logic [RC_W-1:0]       retry_q,  retry_d;
    logic [LOSS_CNT_W-1:0] loss_q,   loss_d;
    logic [LF_W-1:0]       low_q,    low_d;
    logic                  pll_rst_q, sys_rst_q, ready_q, fail_q;

    // NOTE: every comb output gets a default before the case, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;
        low_d   = '0;
        unique case (state_q)
            ST_PLLRST: begin
                if (timer_q == TMR_W'(PLL_RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout on the same cycle.
                if (lock_s) begin
                    state_d = ST_STABLE;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    timer_d = '0;
                    if (retry_q == RC_W'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_PLLRST;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end
            end
            ST_RUN: begin
                timer_d = '0;
                if (!lock_s) begin
                    low_d = low_q + 1'b1;
                    if (low_q == LF_W'(LOSS_FILTER - 1)) begin
                        state_d = ST_PLLRST;
                        low_d   = '0;
                        retry_d = '0;
                        if (loss_q != '1) loss_d = loss_q + 1'b1;
                    end
                end
            end
            ST_FAIL: begin
                timer_d = '0;
            end
            default: begin
                state_d = ST_PLLRST;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change together with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_PLLRST;
            timer_q   <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            low_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            low_q     <= low_d;
            pll_rst_q <= (state_d == ST_PLLRST);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq: directed scenarios plus random lock activity,
// every cycle compared against a cycle-level reference of the sequencing rules.
module tb_pll_lock_rst_seq;

    localparam int SS = 2;
    localparam int P  = 4;
    localparam int T  = 32;
    localparam int S  = 8;
    localparam int MR = 2;
    localparam int LF = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock;
    logic       pll_rst, sys_rst, ready, fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int    n_vec = 0;
    int    n_err = 0;
    string scen  = "init";

    pll_lock_rst_seq #(
        .SYNC_STAGES(SS), .PLL_RST_CYCLES(P), .LOCK_TIMEOUT(T),
        .STABLE_CYCLES(S), .MAX_RETRY(MR), .LOSS_FILTER(LF)
    ) dut (
        .clk(clk), .rst(rst), .lock(lock),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .state(state)
    );

    always #5 clk = ~clk;

    // Reference: phase 0=pll reset, 1=wait lock, 2=stable, 3=run, 4=fail.
    int m_phase, m_t, m_retry, m_loss, m_low;
    bit m_sh[SS];

    task automatic model_reset();
        m_phase = 0; m_t = 0; m_retry = 0; m_loss = 0; m_low = 0;
        for (int i = 0; i < SS; i++) m_sh[i] = 1'b0;
    endtask

    task automatic model_step(input bit l);
        bit seen;
        seen = m_sh[SS-1];
        for (int i = SS - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
        m_sh[0] = l;
        case (m_phase)
            0: if (m_t == P - 1) begin m_phase = 1; m_t = 0; end else m_t++;
            1: begin
                if (seen) begin
                    m_phase = 2; m_t = 0;
                end else if (m_t == T - 1) begin
                    m_t = 0;
                    if (m_retry == MR) m_phase = 4;
                    else begin m_retry++; m_phase = 0; end
                end else m_t++;
            end
            2: begin
                if (!seen) begin m_phase = 1; m_t = 0; end
                else if (m_t == S - 1) begin m_phase = 3; m_t = 0; m_low = 0; end
                else m_t++;
            end
            3: begin
                m_low = seen ? 0 : m_low + 1;
                if (m_low == LF) begin
                    m_phase = 0; m_t = 0; m_low = 0; m_retry = 0;
                    if (m_loss < 255) m_loss++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0d expected %0d at %0t", scen, tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("pll_rst", 32'(pll_rst), 32'(m_phase == 0));
        check("sys_rst", 32'(sys_rst), 32'(m_phase != 3));
        check("ready",   32'(ready),   32'(m_phase == 3));
        check("fail",    32'(fail),    32'(m_phase == 4));
        check("state",   32'(state),   32'(m_phase));
        check("retry",   32'(retry_cnt), 32'(m_retry));
        check("loss",    32'(loss_cnt),  32'(m_loss));
    endtask

    task automatic cyc(input bit l);
        lock = l;
        @(posedge clk);
        model_step(l);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input bit l, input int n);
        repeat (n) cyc(l);
    endtask

    task automatic do_reset();
        lock = 1'b0;
        rst  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    task automatic run_until_stable_t(input int tgt, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            cyc(1'b1);
            hit = (m_phase == 2) && (m_t == tgt);
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        rst  = 1'b1;
        lock = 1'b0;
        model_reset();

        // 1: clean bring-up.
        scen = "bringup";
        do_reset();
        check("rst_pll_rst", 32'(pll_rst), 32'd1);
        check("rst_ready",   32'(ready),   32'd0);
        run(1'b0, 3);
        check("pll_rst_hi", 32'(pll_rst), 32'd1);
        run(1'b0, 1);
        check("pll_rst_lo", 32'(pll_rst), 32'd0);
        run(1'b0, 10);
        run(1'b1, 10);
        check("ready_early", 32'(ready), 32'd0);
        run(1'b1, 1);
        check("ready_up",  32'(ready),     32'd1);
        check("sys_rst_dn", 32'(sys_rst),  32'd0);
        check("retry0",    32'(retry_cnt), 32'd0);

        // 2: two timeouts, then lock.
        scen = "retry";
        do_reset();
        run(1'b0, P + T + P + T + P + 10);
        check("retry2_wait", 32'(retry_cnt), 32'd2);
        check("state_wait",  32'(state),     32'd1);
        run(1'b1, 11);
        check("ready_after_retry", 32'(ready), 32'd1);
        check("no_fail",           32'(fail),  32'd0);
        check("retry2_run", 32'(retry_cnt), 32'd2);

        // 5: RUN glitch filter, continuing from RUN with retries used.
        scen = "loss";
        run(1'b0, 2);
        run(1'b1, 5);
        check("short_glitch_ready", 32'(ready),    32'd1);
        check("short_glitch_loss",  32'(loss_cnt), 32'd0);
        run(1'b0, 5);
        check("loss_sys_rst", 32'(sys_rst),   32'd1);
        check("loss_cnt1",    32'(loss_cnt),  32'd1);
        check("loss_state",   32'(state),     32'd0);
        check("loss_retry0",  32'(retry_cnt), 32'd0);
        run(1'b1, 20);
        check("rerun_ready", 32'(ready), 32'd1);

        // 6: async reset while in STABLE.
        scen = "async_rst";
        run(1'b0, 5);
        run_until_stable_t(2, "reach_stable");
        #2 rst = 1'b1;
        #1;
        check("ar_pll_rst", 32'(pll_rst),   32'd1);
        check("ar_sys_rst", 32'(sys_rst),   32'd1);
        check("ar_ready",   32'(ready),     32'd0);
        check("ar_state",   32'(state),     32'd0);
        check("ar_loss",    32'(loss_cnt),  32'd0);
        check("ar_retry",   32'(retry_cnt), 32'd0);
        model_reset();
        lock = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 3);

        // 4: one-cycle glitch during STABLE at timer 5.
        scen = "stable_glitch";
        do_reset();
        run_until_stable_t(3, "reach_t3");
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        check("glitch_back_wait", 32'(state),     32'd1);
        check("glitch_retry",     32'(retry_cnt), 32'd0);
        run(1'b1, 8);
        check("glitch_not_ready", 32'(ready), 32'd0);
        cyc(1'b1);
        check("glitch_ready", 32'(ready), 32'd1);

        // 3: permanent failure; later lock is ignored.
        scen = "fail";
        do_reset();
        run(1'b0, 3 * T + 3 * P + 5);
        check("fail_flag",  32'(fail),    32'd1);
        check("fail_state", 32'(state),   32'd4);
        check("fail_sys",   32'(sys_rst), 32'd1);
        run(1'b1, 20);
        check("fail_sticky", 32'(fail),  32'd1);
        check("fail_stay",   32'(state), 32'd4);

        // Random lock activity against the reference.
        scen = "random";
        for (int r = 0; r < 6; r++) begin
            int done;
            do_reset();
            done = 0;
            while (done < 300) begin
                bit lv;
                int len;
                lv  = 1'($urandom_range(0, 1));
                len = lv ? int'($urandom_range(1, 30))
                         : (($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 50))
                                                        : int'($urandom_range(1, 4)));
                run(lv, len);
                done += len;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
